multiword_add_sequencer: RTL and testbench
==========================================

Name: multiword_add_sequencer

Overview:
Sequences one SLICE-bit ripple-adder slice over multiple cycles to add two WIDTH-bit operands, LSB slice first, with the carry held in a register between slices. Operands enter through a valid/ready input handshake. The result leaves through a valid/ready output handshake. It sits between operand producers and result consumers wherever a full-width adder costs too much area.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of SLICE
SLICE, 4, adder slice width in bits
NSLICE (localparam), WIDTH/SLICE, number of slice cycles per operation

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands present
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
carry_in  input  1  carry into slice 0
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
carry_out  output  1  carry out of the top slice
busy  output  1  high in RUN

Behaviour:
- Interface: one clock `clk`; synchronous, active-high `reset`, sampled on the rising edge of `clk`.
- State machine:
  - IDLE -> RUN on accept (in_valid && in_ready).
  - RUN -> DONE after NSLICE slice cycles.
  - DONE -> IDLE on out_valid && out_ready.
- Outputs by state:
  - in_ready = 1 only in IDLE.
  - busy = 1 only in RUN.
  - out_valid = 1 only in DONE.
- Accept: a, b and carry_in are registered; slice index k = 0; carry register = carry_in. Inputs are ignored outside IDLE.
- RUN, each cycle (slice k):
  - {c, s} = a[k] + b[k] + carry_reg, where a[k] and b[k] are the SLICE-bit fields [k*SLICE +: SLICE].
  - s is written to sum field k; carry_reg = c; k increments.
  - After slice NSLICE-1, carry_out = c and the state moves to DONE.
- Latency: accept on edge t gives out_valid high after edge t+NSLICE (4 cycles at the defaults).
- Arithmetic: result is modulo 2^WIDTH; carry_out is bit WIDTH of a+b+carry_in.
- Backpressure: in DONE with out_ready=0, sum, carry_out and out_valid hold unchanged indefinitely.
- Back-to-back: in_ready rises the cycle after the output handshake. No same-cycle output-handshake/input-accept overlap; worst throughput is 1 op per NSLICE+2 cycles.
- sum is undefined-but-stable during RUN; consumers use it only when out_valid=1.
- Reset (any state, including mid-RUN or DONE):
  - next state IDLE; k = 0; carry_reg = 0; sum = 0; carry_out = 0.
  - out_valid = 0; busy = 0; in_ready = 1 after the reset edge.
  - Any in-flight operation is discarded.
- reset has priority over every handshake in the same cycle.

Optional Feature:
- Macro MWADD_SUB_EN.
- Defined:
  - Adds input port `sub` (1 bit), captured at accept.
  - With sub=1, the operation is a + ~b + 1: carry_in is ignored and carry_reg is initialised to 1. carry_out=1 means no borrow.
  - With sub=0, behaviour is identical to the base block.
- Undefined: no `sub` port; addition only.

Decomposition:
- Shared package mwadd_pkg holds:
  - state typedef / localparams (ST_IDLE, ST_RUN, ST_DONE, 2-bit);
  - default WIDTH and SLICE constants;
  - function for the slice-count width, $clog2(NSLICE).
- One sub-module, add_slice: combinational SLICE-bit adder (a, b, cin -> s, cout). The sequencer instantiates it once and muxes slice fields into it.

Test Plan:
- a=16'h0001, b=16'hFFFF, carry_in=0 -> sum=16'h0000, carry_out=1; out_valid 4 cycles after accept.
- a=16'h1234, b=16'h4321, carry_in=1 -> sum=16'h5556, carry_out=0.
- Backpressure: complete 16'h00FF+16'h0001 with out_ready=0 for 3 cycles -> sum=16'h0100 held stable, in_ready=0 throughout; out_valid drops the cycle after out_ready=1.
- Reset after 2 RUN cycles:
  - next cycle out_valid=0, busy=0, in_ready=1, sum=0;
  - following op 16'h0003+16'h0006 -> 16'h0009, carry_out=0.
- Back-to-back: in_valid held high with two queued ops (16'hFFFF+16'hFFFF, cin=1 -> 16'hFFFF, cout=1; then 16'h0000+16'h0000 -> 16'h0000, cout=0) -> second accept exactly 1 cycle after the first output handshake.
- MWADD_SUB_EN: sub=1, a=16'h0005, b=16'h0007 -> sum=16'hFFFE, carry_out=0; a=16'h0007, b=16'h0005 -> 16'h0002, carry_out=1.

Source files
------------

// File: rtl/mwadd_pkg.sv
// Shared types and constants for the multiword add sequencer: FSM state
// encoding, default geometry and the slice-index width helper.
package mwadd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 4;

    // A single-slice configuration still needs a 1-bit index register.
    function automatic int slice_idx_w(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational SLICE-bit adder slice; the sequencer reuses one instance
// for every field of the operands.
module add_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_cin,
    output logic [SLICE-1:0] o_s,
    output logic             o_cout
);

    assign {o_cout, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{SLICE{1'b0}}, i_cin};

endmodule

// File: rtl/multiword_add_sequencer.sv
// Multi-cycle WIDTH-bit adder built from one SLICE-bit slice, LSB field first.
// Define MWADD_SUB_EN to add the `sub` port (a + ~b + 1 subtraction).
module multiword_add_sequencer
    import mwadd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef MWADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = slice_idx_w(NSLICE);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] w_sum_next;
    logic [KW-1:0]    r_k;
    logic             r_carry;
    logic             r_cout;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic [SLICE-1:0] w_s;
    logic             w_c;
    logic [SLICE-1:0] w_a_fld [NSLICE];
    logic [SLICE-1:0] w_b_fld [NSLICE];

    // Subtraction folds into addition: invert b once at capture, seed carry with 1.
`ifdef MWADD_SUB_EN
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub ? 1'b1 : carry_in;
`else
    assign w_b_eff   = b;
    assign w_cin_eff = carry_in;
`endif

    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_last   = (r_k == KW'(NSLICE - 1));

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_field
            assign w_a_fld[gi] = r_a[gi*SLICE +: SLICE];
            assign w_b_fld[gi] = r_b[gi*SLICE +: SLICE];
            // Only the field selected by k takes the new slice result.
            assign w_sum_next[gi*SLICE +: SLICE] =
                (r_k == KW'(gi)) ? w_s : r_sum[gi*SLICE +: SLICE];
        end
    endgenerate

    add_slice #(
        .SLICE (SLICE)
    ) u_add_slice (
        .i_a    (w_a_fld[r_k]),
        .i_b    (w_b_fld[r_k]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_eff;
            r_k     <= '0;
            r_carry <= w_cin_eff;
        end else if (r_state == ST_RUN) begin
            r_sum   <= w_sum_next;
            r_carry <= w_c;
            r_k     <= r_k + KW'(1);
            if (w_last) begin
                r_cout <= w_c;
            end
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_cout;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer: vector table, scoreboard
// queue and hand-written multi-cycle sequences (latency, backpressure, reset, back-to-back).
module tb_multiword_add_sequencer;

    localparam int WIDTH = 16;
    localparam int SLICE = 4;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] s;
        logic             co;
    } vec_t;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             co;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cin_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             busy;
`ifdef MWADD_SUB_EN
    logic             sub_i;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_hs = 0;
    int   last_acc = 0;
    exp_t exp_q[$];
    vec_t tbl[9];

    multiword_add_sequencer #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .carry_in  (cin_i),
`ifdef MWADD_SUB_EN
        .sub       (sub_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Scoreboard: a handshake is pending when out_valid && out_ready at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                timeout("unexpected_result");
            end else begin
                e = exp_q.pop_front();
                chk("sum", 32'(sum), 32'(e.s));
                chk("carry_out", 32'(carry_out), 32'(e.co));
                $display("result sum=%h carry_out=%b (expected %h/%b)", sum, carry_out, e.s, e.co);
            end
            last_hs = cyc + 1;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tc, input logic push,
                        input logic [WIDTH-1:0] es, input logic eco);
        int   n;
        exp_t e;
        n = 0;
        a_i = ta;
        b_i = tb;
        cin_i = tc;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            timeout("accept");
        end else begin
            if (push) begin
                e.s = es;
                e.co = eco;
                exp_q.push_back(e);
            end
            last_acc = cyc + 1;
            $display("op a=%h b=%h cin=%b accepted at cycle %0d", ta, tb, tc, last_acc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) timeout("drain");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   n;
        logic [WIDTH:0] m;
        logic [WIDTH-1:0] ra, rb;
        logic rc;

        tbl[0] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1};
        tbl[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        tbl[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        tbl[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        tbl[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
        tbl[6] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};
        tbl[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        tbl[8] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a_i = '0;
        b_i = '0;
        cin_i = 1'b0;
`ifdef MWADD_SUB_EN
        sub_i = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_carry_out", 32'(carry_out), 32'd0);
        @(posedge clk);
        #1;

        // Latency: accept on edge t, out_valid visible after edge t+4.
        send(tbl[0].a, tbl[0].b, tbl[0].cin, 1'b1, tbl[0].s, tbl[0].co);
        in_valid = 1'b0;
        @(negedge clk);
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_in_ready", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("latency", 32'(n), 32'd4);
        wait_done();

        for (int i = 1; i < 9; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b1, tbl[i].s, tbl[i].co);
            in_valid = 1'b0;
            wait_done();
        end

        for (int i = 0; i < 6; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom_range(0, 1));
            m = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
            send(ra, rb, rc, 1'b1, m[WIDTH-1:0], m[WIDTH]);
            in_valid = 1'b0;
            wait_done();
        end

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        send(16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0100, 1'b0);
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) timeout("bp_out_valid");
        for (int i = 0; i < 3; i++) begin
            chk("bp_sum_hold", 32'(sum), 32'h0100);
            chk("bp_valid_hold", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_valid_drop", 32'(out_valid), 32'd0);
        chk("bp_in_ready_back", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Reset two slice cycles into an operation discards it.
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h0000, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_sum", 32'(sum), 32'd0);
        @(posedge clk);
        #1;
        send(16'h0003, 16'h0006, 1'b0, 1'b1, 16'h0009, 1'b0);
        in_valid = 1'b0;
        wait_done();

        // Back-to-back: in_valid stays high across both operations.
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b1);
        send(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0);
        in_valid = 1'b0;
        chk("b2b_accept_gap", 32'(last_acc - last_hs), 32'd1);
        wait_done();

`ifdef MWADD_SUB_EN
        sub_i = 1'b1;
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        in_valid = 1'b0;
        wait_done();
        send(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
        in_valid = 1'b0;
        wait_done();
        sub_i = 1'b0;
        send(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h000C, 1'b0);
        in_valid = 1'b0;
        wait_done();
`endif

        repeat (4) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
